mem_port_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 34 +++
 rtl/mem_load_extend.sv | 22 ++
 rtl/mem_port_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and size decoding for the byte-serial memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_XFER = 2'd1,
    D_XFER  = 2'd2,
    DONE    = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_e;

  // Load/store size codes carried on funct3.
  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  // Number of single-byte memory accesses for a size code; unknown codes are words.
  function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
    logic [2:0] n;
    case (funct3)
      SZ_B, SZ_BU: n = 3'd1;
      SZ_H, SZ_HU: n = 3'd2;
      default:     n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Combines four little-endian byte lanes into a sign/zero-extended load result.
module mem_load_extend
  import mem_arb_pkg::*;
(
  input  logic [3:0][7:0] lanes_i,
  input  logic [2:0]      funct3_i,
  output logic [31:0]     data_o
);

  // Select width and extension from the size code; lane 0 lands in bits 7:0.
  always_comb begin
    data_o = lanes_i;
    case (funct3_i)
      SZ_B:    data_o = {{24{lanes_i[0][7]}}, lanes_i[0]};
      SZ_H:    data_o = {{16{lanes_i[1][7]}}, lanes_i[1], lanes_i[0]};
      SZ_BU:   data_o = {24'h000000, lanes_i[0]};
      SZ_HU:   data_o = {16'h0000, lanes_i[1], lanes_i[0]};
      default: data_o = lanes_i;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a byte-wide memory between the fetch and load/store ports, serialising
// each granted request into single-byte accesses.
module mem_port_arbiter
  import mem_arb_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        if_read,
  input  logic [31:0] if_address,
  output logic [31:0] if_readdata,
  output logic        if_busywait,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_address,
  input  logic [31:0] d_writedata,
  input  logic [2:0]  d_funct3,
  output logic [31:0] d_readdata,
  output logic        d_busywait,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [7:0]  mem_writedata,
  input  logic [7:0]  mem_readdata,
  input  logic        mem_busywait
);

  arb_state_e      state_q, state_d;
  arb_owner_e      owner_q, owner_d;
  logic [31:0]     base_q, base_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [2:0]      count_q, count_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0][7:0] lanes_q, lanes_d;
  logic [31:0]     if_rdata_q, if_rdata_d;
  logic [31:0]     d_rdata_q, d_rdata_d;
  logic            mem_read_q, mem_read_d;
  logic            mem_write_q, mem_write_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [7:0]      mem_wdata_q, mem_wdata_d;

  logic            d_req;
  logic            xfer;
  logic            byte_done;
  logic            last_byte;
  logic [1:0]      nxt_idx;
  logic [3:0][7:0] lanes_cap;
  logic [31:0]     load_word;

  assign d_req     = d_read ^ d_write;
  assign xfer      = (state_q == IF_XFER) || (state_q == D_XFER);
  assign byte_done = xfer && (mem_read_q || mem_write_q) && !mem_busywait;
  assign last_byte = ({1'b0, idx_q} == (count_q - 3'd1));
  assign nxt_idx   = idx_q + 2'd1;

  // Busywait drops only during the owning port's DONE cycle.
  assign if_busywait = if_read && !((state_q == DONE) && (owner_q == OWN_IF));
  assign d_busywait  = d_req   && !((state_q == DONE) && (owner_q == OWN_D));

  assign if_readdata   = if_rdata_q;
  assign d_readdata    = d_rdata_q;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_address   = mem_addr_q;
  assign mem_writedata = mem_wdata_q;

  // Byte lanes including the byte arriving this cycle, so the final byte is
  // visible to the extender on the same edge that enters DONE.
  always_comb begin
    lanes_cap = lanes_q;
    if (byte_done && mem_read_q) lanes_cap[idx_q] = mem_readdata;
  end

  mem_load_extend u_extend (
    .lanes_i  (lanes_cap),
    .funct3_i (funct3_q),
    .data_o   (load_word)
  );

  // Arbitration, byte sequencing and result capture.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    funct3_d    = funct3_q;
    count_d     = count_q;
    idx_d       = idx_q;
    lanes_d     = lanes_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (d_req) begin
          state_d     = D_XFER;
          owner_d     = OWN_D;
          base_d      = d_address;
          wdata_d     = d_writedata;
          funct3_d    = d_funct3;
          count_d     = size_bytes(d_funct3);
          idx_d       = 2'd0;
          lanes_d     = '0;
          mem_read_d  = d_read;
          mem_write_d = d_write;
          mem_addr_d  = d_address;
          mem_wdata_d = d_writedata[7:0];
        end else if (if_read) begin
          state_d     = IF_XFER;
          owner_d     = OWN_IF;
          base_d      = if_address;
          wdata_d     = '0;
          funct3_d    = SZ_W;
          count_d     = 3'd4;
          idx_d       = 2'd0;
          lanes_d     = '0;
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
          mem_addr_d  = if_address;
          mem_wdata_d = '0;
        end
      end

      IF_XFER, D_XFER: begin
        lanes_d = lanes_cap;
        if (byte_done) begin
          if (last_byte) begin
            state_d     = DONE;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            if (mem_read_q) begin
              if (owner_q == OWN_IF) if_rdata_d = load_word;
              else                   d_rdata_d  = load_word;
            end
          end else begin
            idx_d       = nxt_idx;
            mem_addr_d  = base_q + {30'd0, nxt_idx};
            mem_wdata_d = wdata_q[{nxt_idx, 3'b000} +: 8];
          end
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any access in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      base_q      <= '0;
      wdata_q     <= '0;
      funct3_q    <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      lanes_q     <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      funct3_q    <= funct3_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      lanes_q     <= lanes_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: expected byte accesses and load results are queued when a
// request is issued; monitors pop and compare as the DUT presents them.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_read;
  logic [31:0] if_address;
  logic [31:0] if_readdata;
  logic        if_busywait;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_address;
  logic [31:0] d_writedata;
  logic [2:0]  d_funct3;
  logic [31:0] d_readdata;
  logic        d_busywait;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [7:0]  mem_writedata;
  logic [7:0]  mem_readdata = 8'h00;
  logic        mem_busywait = 1'b0;

  always #5 clock = ~clock;

  mem_port_arbiter dut (
    .clock         (clock),
    .reset         (reset),
    .if_read       (if_read),
    .if_address    (if_address),
    .if_readdata   (if_readdata),
    .if_busywait   (if_busywait),
    .d_read        (d_read),
    .d_write       (d_write),
    .d_address     (d_address),
    .d_writedata   (d_writedata),
    .d_funct3      (d_funct3),
    .d_readdata    (d_readdata),
    .d_busywait    (d_busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
  );

  typedef struct packed {
    logic [31:0] a;
    logic        wr;
    logic [7:0]  d;
  } acc_t;

  int          checks = 0;
  int          errors = 0;
  acc_t        exp_acc[$];
  logic [31:0] exp_if[$];
  logic [31:0] exp_d[$];
  logic [7:0]  mem     [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];
  int          waits   = 0;
  int          wcnt    = 0;
  int          acc_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ {a[14:8], 1'b1} ^ a[31:24] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] env_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  function automatic int nbytes(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  // Reference load: little-endian sum of bytes, signed codes wrap to negative.
  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] f3);
    int     n;
    longint v;
    n = nbytes(f3);
    v = 0;
    for (int i = 0; i < n; i++) v += longint'(ref_rd(addr + 32'(i))) << (8 * i);
    if ((f3 == 3'b000 || f3 == 3'b001) && v >= (longint'(1) << (8 * n - 1)))
      v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    mem[a]     = b;
    ref_mem[a] = b;
  endtask

  // kind: 0 fetch, 1 load, 2 store
  task automatic push_expect(input int kind, input logic [31:0] addr, input logic [2:0] f3,
                             input logic [31:0] wd);
    int   n;
    acc_t e;
    n = (kind == 0) ? 4 : nbytes(f3);
    if (kind == 0) exp_if.push_back(ref_load(addr, 3'b010));
    if (kind == 1) exp_d.push_back(ref_load(addr, f3));
    for (int i = 0; i < n; i++) begin
      e.a  = addr + 32'(i);
      e.wr = (kind == 2);
      e.d  = (kind == 2) ? wd[8*i +: 8] : 8'h00;
      exp_acc.push_back(e);
      if (kind == 2) ref_mem[e.a] = e.d;
    end
  endtask

  // Memory model and access monitor. Decisions are made at the falling edge:
  // a strobe seen here with no wait completes at the following rising edge.
  always @(negedge clock) begin
    acc_t e;
    if (mem_read || mem_write) begin
      mem_busywait = (wcnt < waits);
      mem_readdata = env_rd(mem_address);
      if (!mem_busywait) begin
        wcnt = 0;
        acc_cnt++;
        if (mem_write) mem[mem_address] = mem_writedata;
        if (exp_acc.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_access: actual addr %h wr %0d expected none", mem_address, mem_write);
        end else begin
          e = exp_acc.pop_front();
          check("acc_addr", mem_address, e.a);
          check("acc_kind", 32'(mem_write), 32'(e.wr));
          if (e.wr) check("acc_wdata", 32'(mem_writedata), 32'(e.d));
        end
      end else begin
        wcnt++;
      end
    end else begin
      mem_busywait = 1'b0;
      wcnt = 0;
    end
  end

  // Result monitor: a port's DONE cycle is request high with busywait low.
  always @(negedge clock) begin
    if (!reset && if_read && !if_busywait) begin
      if (exp_if.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_if_done: actual %h expected none", if_readdata);
      end else check("if_readdata", if_readdata, exp_if.pop_front());
    end
    if (!reset && d_read && !d_write && !d_busywait) begin
      if (exp_d.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_d_done: actual %h expected none", d_readdata);
      end else check("d_readdata", d_readdata, exp_d.pop_front());
    end
  end

  task automatic wait_low(input bit is_if, output int cyc);
    cyc = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clock); #1;
      cyc++;
      if (!(is_if ? if_busywait : d_busywait)) return;
    end
    checks++; errors++;
    $display("FAIL busywait_timeout: actual still high expected low (port %s)", is_if ? "if" : "d");
  endtask

  task automatic wait_acc(input int target);
    for (int k = 0; k < 300; k++) begin
      if (acc_cnt >= target) return;
      @(negedge clock); #1;
    end
    checks++; errors++;
    $display("FAIL access_timeout: actual %0d expected %0d", acc_cnt, target);
  endtask

  task automatic do_txn(input int kind, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] wd, input int w);
    int cyc;
    int n;
    @(negedge clock); #1;
    waits = w;
    push_expect(kind, addr, f3, wd);
    n = (kind == 0) ? 4 : nbytes(f3);
    if (kind == 0) begin
      if_read = 1'b1; if_address = addr;
    end else begin
      d_read = (kind == 1); d_write = (kind == 2);
      d_address = addr; d_funct3 = f3; d_writedata = wd;
    end
    wait_low(kind == 0, cyc);
    check("latency", 32'(cyc), 32'(n * (1 + w) + 1));
    if_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: actual running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int          cyc;
    int          base;
    logic [2:0]  f3_tab [8];
    int          kind;
    logic [31:0] addr;

    reset = 1'b1;
    if_read = 1'b0; if_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_writedata = '0; d_funct3 = '0;
    #2;
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    check("rst_mem_wdata", 32'(mem_writedata), 32'd0);
    check("rst_if_readdata", if_readdata, 32'd0);
    check("rst_d_readdata", d_readdata, 32'd0);
    check("rst_busy", {30'd0, if_busywait, d_busywait}, 32'd0);
    @(negedge clock); #1;
    reset = 1'b0;

    // Zero-wait LW
    preload(32'h100, 8'h11); preload(32'h101, 8'h22);
    preload(32'h102, 8'h33); preload(32'h103, 8'h44);
    check("lw_model", ref_load(32'h100, 3'b010), 32'h44332211);
    do_txn(1, 32'h100, 3'b010, 32'h0, 0);

    // SH: two bytes only
    do_txn(2, 32'h202, 3'b001, 32'h1234BEEF, 0);

    // Simultaneous fetch and LB: data first
    @(negedge clock); #1;
    waits = 0;
    preload(32'h10, 8'h80);
    check("lb_model", ref_load(32'h10, 3'b000), 32'hFFFFFF80);
    push_expect(1, 32'h10, 3'b000, 32'h0);
    push_expect(0, 32'h0, 3'b010, 32'h0);
    d_read = 1'b1; d_address = 32'h10; d_funct3 = 3'b000;
    if_read = 1'b1; if_address = 32'h0;
    wait_low(1'b0, cyc);
    check("sim_d_latency", 32'(cyc), 32'd2);
    check("sim_if_stalled", 32'(if_busywait), 32'd1);
    d_read = 1'b0;
    wait_low(1'b1, cyc);
    check("sim_if_latency", 32'(cyc), 32'd6);
    if_read = 1'b0;

    // LHU with two wait cycles per byte
    preload(32'h7, 8'hF0); preload(32'h8, 8'h9A);
    check("lhu_model", ref_load(32'h7, 3'b101), 32'h00009AF0);
    do_txn(1, 32'h7, 3'b101, 32'h0, 2);

    // Wrap-around LW
    do_txn(1, 32'hFFFFFFFE, 3'b010, 32'h0, 0);

    // Reset during byte 2 of a fetch
    @(negedge clock); #1;
    waits = 2;
    push_expect(0, 32'h500, 3'b010, 32'h0);
    if_read = 1'b1; if_address = 32'h500;
    base = acc_cnt;
    wait_acc(base + 2);
    @(negedge clock); #1;
    reset = 1'b1;
    #1;
    check("mid_rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    check("mid_rst_address", mem_address, 32'd0);
    check("mid_rst_if_readdata", if_readdata, 32'd0);
    check("mid_rst_d_readdata", d_readdata, 32'd0);
    check("mid_rst_if_busy", 32'(if_busywait), 32'd1);
    exp_acc.delete();
    exp_if.delete();
    if_read = 1'b0;
    @(negedge clock); #1;
    reset = 1'b0;
    do_txn(0, 32'h500, 3'b010, 32'h0, 0);

    // SW withdrawn after its first byte, fetch of the same word queued behind it
    @(negedge clock); #1;
    waits = 0;
    push_expect(2, 32'h400, 3'b010, 32'hCAFE0B1E);
    d_write = 1'b1; d_address = 32'h400; d_funct3 = 3'b010; d_writedata = 32'hCAFE0B1E;
    base = acc_cnt;
    wait_acc(base + 1);
    d_write = 1'b0;
    push_expect(0, 32'h400, 3'b010, 32'h0);
    if_read = 1'b1; if_address = 32'h400;
    wait_low(1'b1, cyc);
    check("withdraw_if_latency", 32'(cyc), 32'd10);
    if_read = 1'b0;

    // d_read and d_write together is not a request
    @(negedge clock); #1;
    d_read = 1'b1; d_write = 1'b1; d_address = 32'h600;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock); #1;
      check("illegal_busy", 32'(d_busywait), 32'd0);
      check("illegal_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    end
    d_read = 1'b0; d_write = 1'b0;

    // Randomised traffic including illegal size codes and wrap-around addresses
    f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    for (int t = 0; t < 50; t++) begin
      kind = int'($urandom_range(0, 2));
      case ($urandom_range(0, 3))
        0:       addr = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
        1:       addr = $urandom;
        default: addr = 32'h1000 + 32'($urandom_range(0, 15));
      endcase
      do_txn(kind, addr, f3_tab[$urandom_range(0, 7)], $urandom, int'($urandom_range(0, 2)));
    end

    repeat (3) @(negedge clock);
    #1;
    check("acc_queue_empty", 32'(exp_acc.size()), 32'd0);
    check("if_queue_empty", 32'(exp_if.size()), 32'd0);
    check("d_queue_empty", 32'(exp_d.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
